// File: rtl/stopwatch_timer.sv
// stopwatch_timer: BCD up/down timer with preset entry, lap hold and done flag.
// Drives an active-low multiplexed 7-segment display, one digit per scan step.
module stopwatch_timer #(
  parameter int TICK_DIV   = 5000000,
  parameter int SCAN_DIV   = 100000,
  parameter int MIN_DIGITS = 1
) (
  input  logic                  clk_org,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  clr,
  input  logic                  mode,
  input  logic                  preset_en,
  input  logic                  preset_inc,
  input  logic                  lap,
  output logic [7:0]            seg,
  output logic [MIN_DIGITS+2:0] side,
  output logic                  done,
  output logic                  running
);

  localparam int N  = MIN_DIGITS + 3;
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int IW = $clog2(N);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);

  typedef logic [N-1:0][3:0] bcd_t;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;

  function automatic logic [3:0] top_of(input int i);
    return (i == 2) ? 4'd5 : 4'd9;
  endfunction

  function automatic bcd_t max_val();
    bcd_t r;
    for (int i = 0; i < N; i++) r[i] = top_of(i);
    return r;
  endfunction

  localparam bcd_t CNT_MAX = max_val();

  function automatic bcd_t bcd_inc(input bcd_t v, input int from);
    bcd_t r = v;
    logic c = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (c && i >= from) begin
        if (r[i] == top_of(i)) r[i] = 4'd0;
        else begin
          r[i] = r[i] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic bcd_t bcd_dec(input bcd_t v);
    bcd_t r = v;
    logic b = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (b) begin
        if (r[i] == 4'd0) r[i] = top_of(i);
        else begin
          r[i] = r[i] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    unique case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  state_e          state_q, state_d;
  bcd_t            cnt_q, cnt_d, pre_q, pre_d, snap_q, snap_d;
  bcd_t            cnt_up, cnt_dn, pre_up, disp;
  logic            hold_q, hold_d, mode_q, mode_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [SW-1:0]   scan_q, scan_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [7:0]      seg_q, seg_d;
  logic [N-1:0]    side_q, side_d;
  logic            done_q, run_q;
  logic            start_q, clr_q, inc_q, lap_q;
  logic            start_ev, clr_ev, inc_ev, lap_ev;
  logic            tick, step;

  assign start_ev = start & ~start_q;
  assign clr_ev   = clr & ~clr_q;
  assign inc_ev   = preset_inc & ~inc_q;
  assign lap_ev   = lap & ~lap_q;
  assign tick     = (presc_q == TICK_LAST);
  assign cnt_up   = bcd_inc(cnt_q, 0);
  assign cnt_dn   = bcd_dec(cnt_q);
  assign pre_up   = bcd_inc(pre_q, 2);

  // Run/pause/done control, counting, preset entry and lap capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    snap_d  = snap_q;
    hold_d  = hold_q;
    mode_d  = mode_q;
    presc_d = presc_q;
    if (clr_ev) begin
      state_d = IDLE;
      hold_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          mode_d = mode;
          cnt_d  = mode_q ? pre_q : '0;
          if (inc_ev && preset_en) pre_d = pre_up;
          if (start_ev && !(mode_q && pre_q == '0)) begin
            state_d = RUN;
            presc_d = '0;
          end
        end
        RUN: begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (lap_ev) begin
            hold_d = ~hold_q;
            if (!hold_q) snap_d = cnt_q;
          end
          if (start_ev) begin
            state_d = PAUSE;
          end else if (tick) begin
            cnt_d = mode_q ? cnt_dn : cnt_up;
            if (mode_q ? (cnt_dn == '0) : (cnt_up == CNT_MAX)) begin
              state_d = DONE;
              hold_d  = 1'b0;
            end
          end
        end
        PAUSE: begin
          if (start_ev) state_d = RUN;
        end
        DONE: begin
        end
      endcase
    end
  end

  // Display source selection and digit scan.
  always_comb begin
    disp = cnt_q;
    if (state_q == IDLE && preset_en) disp = pre_q;
    else if (hold_q) disp = snap_q;
    step   = (scan_q == SCAN_LAST);
    scan_d = step ? '0 : scan_q + SW'(1);
    idx_d  = idx_q;
    side_d = side_q;
    seg_d  = seg_q;
    if (step) begin
      idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      side_d = ~(N'(1) << idx_d);
      seg_d  = {(idx_d != IW'(1)), seg7(disp[idx_d])};
    end
  end

  // State register for all flops; reset wins over every input.
  always_ff @(posedge clk_org) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pre_q   <= '0;
      snap_q  <= '0;
      hold_q  <= 1'b0;
      mode_q  <= 1'b0;
      presc_q <= '0;
      scan_q  <= '0;
      idx_q   <= '0;
      seg_q   <= 8'hC0;
      side_q  <= ~N'(1);
      done_q  <= 1'b0;
      run_q   <= 1'b0;
      start_q <= 1'b0;
      clr_q   <= 1'b0;
      inc_q   <= 1'b0;
      lap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      snap_q  <= snap_d;
      hold_q  <= hold_d;
      mode_q  <= mode_d;
      presc_q <= presc_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      side_q  <= side_d;
      done_q  <= (state_d == DONE);
      run_q   <= (state_d == RUN);
      start_q <= start;
      clr_q   <= clr;
      inc_q   <= preset_inc;
      lap_q   <= lap;
    end
  end

  assign seg     = seg_q;
  assign side    = side_q;
  assign done    = done_q;
  assign running = run_q;

endmodule

// File: tb/tb_stopwatch_timer.sv
// tb_stopwatch_timer: directed scoreboard bench for stopwatch_timer.
// Small dividers keep the full up-count to 9:59.9 short.
module tb_stopwatch_timer;

  logic       clk_org = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       clr = 1'b0;
  logic       mode = 1'b0;
  logic       preset_en = 1'b0;
  logic       preset_inc = 1'b0;
  logic       lap = 1'b0;
  logic [7:0] seg;
  logic [3:0] side;
  logic       done;
  logic       running;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] shown = '0;

  typedef enum int {K_CNT, K_RUN, K_DONE, K_SIDE, K_SEG, K_DISP} kind_e;
  typedef struct {
    kind_e       k;
    logic [15:0] v;
    string       nm;
  } exp_t;

  exp_t sb[$];

  stopwatch_timer #(
    .TICK_DIV(4),
    .SCAN_DIV(2),
    .MIN_DIGITS(1)
  ) dut (
    .clk_org(clk_org),
    .reset(reset),
    .start(start),
    .clr(clr),
    .mode(mode),
    .preset_en(preset_en),
    .preset_inc(preset_inc),
    .lap(lap),
    .seg(seg),
    .side(side),
    .done(done),
    .running(running)
  );

  always #5 clk_org = ~clk_org;

  function automatic logic [3:0] glyph(input logic [7:0] s);
    case (s | 8'h80)
      8'hC0: return 4'd0;
      8'hF9: return 4'd1;
      8'hA4: return 4'd2;
      8'hB0: return 4'd3;
      8'h99: return 4'd4;
      8'h92: return 4'd5;
      8'h82: return 4'd6;
      8'hF8: return 4'd7;
      8'h80: return 4'd8;
      8'h90: return 4'd9;
      default: return 4'hE;
    endcase
  endfunction

  task automatic push_exp(input kind_e k, input logic [15:0] v,
                          input string nm);
    exp_t e;
    e.k = k;
    e.v = v;
    e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic tk(input int n);
    repeat (n) @(posedge clk_org);
    #1;
  endtask

  task automatic ev_start();
    start = 1'b1;
    tk(1);
    start = 1'b0;
  endtask

  task automatic ev_clr();
    clr = 1'b1;
    tk(1);
    clr = 1'b0;
  endtask

  task automatic ev_inc();
    preset_inc = 1'b1;
    tk(1);
    preset_inc = 1'b0;
    tk(1);
  endtask

  // Monitor: rebuild the shown digits from the scan, then retire expectations.
  always @(negedge clk_org) begin
    exp_t        e;
    logic [15:0] act;
    case (side)
      4'b1110: shown[3:0]   = glyph(seg);
      4'b1101: shown[7:4]   = glyph(seg);
      4'b1011: shown[11:8]  = glyph(seg);
      4'b0111: shown[15:12] = glyph(seg);
      default: ;
    endcase
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.k)
        K_CNT:   act = dut.cnt_q;
        K_RUN:   act = {15'd0, running};
        K_DONE:  act = {15'd0, done};
        K_SIDE:  act = {12'd0, side};
        K_SEG:   act = {8'd0, seg};
        default: act = shown;
      endcase
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.nm, act, e.v);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int         p;
    logic [3:0] sx;

    tk(3);
    push_exp(K_CNT, 16'h0000, "rst_cnt");
    push_exp(K_RUN, 16'd0, "rst_running");
    push_exp(K_DONE, 16'd0, "rst_done");
    push_exp(K_SIDE, 16'h000E, "rst_side");
    push_exp(K_SEG, 16'h00C0, "rst_seg");
    reset = 1'b0;

    for (int j = 1; j <= 8; j++) begin
      tk(1);
      p = (j / 2) % 4;
      sx = ~(4'b0001 << p);
      push_exp(K_SIDE, {12'd0, sx}, "scan_side");
      push_exp(K_SEG, (p == 1) ? 16'h0040 : 16'h00C0, "scan_seg");
    end

    ev_start();
    push_exp(K_RUN, 16'd1, "up_running");
    tk(39);
    push_exp(K_CNT, 16'h0009, "up_39");
    tk(1);
    push_exp(K_CNT, 16'h0010, "up_40");
    push_exp(K_RUN, 16'd1, "up_running_40");

    tk(3);
    ev_start();
    push_exp(K_CNT, 16'h0010, "pause_on_tick");
    push_exp(K_RUN, 16'd0, "pause_running");
    tk(20);
    push_exp(K_CNT, 16'h0010, "pause_frozen");
    ev_start();
    push_exp(K_RUN, 16'd1, "resume_running");
    tk(3);
    push_exp(K_CNT, 16'h0010, "resume_pre");
    tk(1);
    push_exp(K_CNT, 16'h0011, "resume_tick");
    tk(1);
    ev_start();
    push_exp(K_RUN, 16'd0, "pause2_running");
    tk(5);
    ev_start();
    tk(1);
    push_exp(K_CNT, 16'h0011, "resume2_pre");
    tk(1);
    push_exp(K_CNT, 16'h0012, "resume2_keep_presc");

    start = 1'b1;
    clr = 1'b1;
    tk(1);
    start = 1'b0;
    clr = 1'b0;
    push_exp(K_RUN, 16'd0, "clr_beats_start");
    tk(1);
    push_exp(K_CNT, 16'h0000, "clr_reload");
    push_exp(K_DONE, 16'd0, "clr_done");

    tk(2);
    ev_start();
    tk(100);
    lap = 1'b1;
    tk(1);
    lap = 1'b0;
    push_exp(K_CNT, 16'h0025, "lap_cnt");
    tk(29);
    push_exp(K_CNT, 16'h0032, "lap_underneath");
    push_exp(K_DISP, 16'h0025, "lap_disp_hold");
    lap = 1'b1;
    tk(1);
    lap = 1'b0;
    start = 1'b1;
    tk(1);
    start = 1'b0;
    push_exp(K_CNT, 16'h0032, "lap_pause_cnt");
    push_exp(K_RUN, 16'd0, "lap_pause_running");
    tk(10);
    push_exp(K_DISP, 16'h0032, "lap_disp_live");
    ev_clr();
    tk(2);

    ev_start();
    tk(7);
    reset = 1'b1;
    tk(1);
    push_exp(K_CNT, 16'h0000, "mid_rst_cnt");
    push_exp(K_RUN, 16'd0, "mid_rst_running");
    push_exp(K_DONE, 16'd0, "mid_rst_done");
    push_exp(K_SIDE, 16'h000E, "mid_rst_side");
    push_exp(K_SEG, 16'h00C0, "mid_rst_seg");
    reset = 1'b0;

    mode = 1'b1;
    preset_en = 1'b1;
    tk(2);
    repeat (3) ev_inc();
    tk(10);
    push_exp(K_CNT, 16'h0300, "preset_cnt");
    push_exp(K_DISP, 16'h0300, "preset_disp");
    ev_start();
    push_exp(K_RUN, 16'd1, "down_running");
    tk(4);
    push_exp(K_CNT, 16'h0299, "down_borrow");
    tk(1195);
    push_exp(K_CNT, 16'h0001, "down_last");
    push_exp(K_DONE, 16'd0, "down_not_done");
    tk(1);
    push_exp(K_CNT, 16'h0000, "down_zero");
    push_exp(K_DONE, 16'd1, "down_done");
    push_exp(K_RUN, 16'd0, "down_stopped");
    ev_start();
    tk(4);
    push_exp(K_CNT, 16'h0000, "done_start_cnt");
    push_exp(K_DONE, 16'd1, "done_start_done");
    push_exp(K_RUN, 16'd0, "done_start_running");

    ev_clr();
    tk(2);
    push_exp(K_CNT, 16'h0300, "clr_preset_reload");
    push_exp(K_DONE, 16'd0, "clr_done_low");
    repeat (56) ev_inc();
    tk(1);
    push_exp(K_CNT, 16'h9500, "preset_950");
    tk(10);
    push_exp(K_DISP, 16'h9500, "preset_950_disp");
    ev_inc();
    tk(1);
    push_exp(K_CNT, 16'h0000, "preset_wrap");
    ev_start();
    tk(2);
    push_exp(K_RUN, 16'd0, "zero_preset_start");

    mode = 1'b0;
    preset_en = 1'b0;
    tk(2);
    push_exp(K_CNT, 16'h0000, "up_idle_zero");
    ev_start();
    tk(23992);
    push_exp(K_CNT, 16'h9598, "sat_pre");
    push_exp(K_DONE, 16'd0, "sat_pre_done");
    tk(4);
    push_exp(K_CNT, 16'h9599, "sat_max");
    push_exp(K_DONE, 16'd1, "sat_done");
    push_exp(K_RUN, 16'd0, "sat_running");
    tk(8);
    push_exp(K_CNT, 16'h9599, "sat_hold");
    push_exp(K_DONE, 16'd1, "sat_done_hold");

    tk(2);
    for (int i = 0; i < 10 && sb.size() > 0; i++) tk(1);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
